multicycle_mips: RTL and testbench

- Multicycle MIPS-32 core: the next generation of the single-cycle core.
- Uses one shared ALU and one unified instruction/data memory port.
- The memory port has a variable-latency req/ready handshake, so the core tolerates wait states.
- Extends the instruction set with bne, andi and ori.
- Adds a trap/halt state, a retire pulse and a retired-instruction counter; sits under the top level beside the unified memory model.

---
 rtl/mips_pkg.sv | 60 ++++++
 rtl/mips_alu.sv | 27 ++
 rtl/multicycle_mips.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_mips.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings and types for the multicycle MIPS core.
// Opcode/funct constants, ALU control and FSM state enums.
package mips_pkg;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2b;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] BNE   = 6'h05;
    localparam logic [5:0] ADDI  = 6'h08;
    localparam logic [5:0] ANDI  = 6'h0c;
    localparam logic [5:0] ORI   = 6'h0d;
    localparam logic [5:0] J     = 6'h02;

    localparam logic [5:0] ADD = 6'h20;
    localparam logic [5:0] SUB = 6'h22;
    localparam logic [5:0] AND = 6'h24;
    localparam logic [5:0] OR  = 6'h25;
    localparam logic [5:0] SLT = 6'h2a;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alucontrol_t;

    typedef enum logic [3:0] {
        RESET,
        FETCH,
        DECODE,
        EXECUTE,
        ALUWB,
        IEXEC,
        IWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH,
        JUMP,
        TRAP
    } state_t;

    function automatic logic funct_ok(input logic [5:0] f);
        return f inside {ADD, SUB, AND, OR, SLT};
    endfunction

    function automatic alucontrol_t funct_alu(input logic [5:0] f);
        case (f)
            SUB:     return ALU_SUB;
            AND:     return ALU_AND;
            OR:      return ALU_OR;
            SLT:     return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// 32-bit MIPS ALU: and/or/add/sub/signed slt with zero flag.
// Shared by the multicycle core and later pipelined work.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alucontrol_t alucontrol,
    output logic [31:0] y,
    output logic        zero
);

    always_comb begin
        y = '0;
        case (alucontrol)
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_SLT: y = {31'b0, $signed(a) < $signed(b)};
            default: y = '0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/multicycle_mips.sv
// Multicycle MIPS-32 core: one shared ALU, one unified memory port
// with req/ready wait states, trap state and retire counter.
module multicycle_mips
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic              retire,
    output logic [CNT_W-1:0]  instret,
    output logic              halted
);

    state_t r_state;
    state_t w_next;

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_aluout;
    logic [31:0] r_mdr;
    logic [31:0] r_rf [32];
    logic        r_retire;
    logic [CNT_W-1:0] r_instret;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;

    logic [31:0] w_alu_a;
    logic [31:0] w_alu_b;
    alucontrol_t w_alu_ctl;
    logic [31:0] w_alu_y;
    logic        w_alu_zero;

    logic        w_take;
    logic        w_done;
    logic        w_rf_we;
    logic [4:0]  w_rf_wa;
    logic [31:0] w_rf_wd;
    logic [31:0] w_addr;

    assign w_op    = r_ir[31:26];
    assign w_rs    = r_ir[25:21];
    assign w_rt    = r_ir[20:16];
    assign w_rd    = r_ir[15:11];
    assign w_funct = r_ir[5:0];
    assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_zimm  = {16'h0000, r_ir[15:0]};

    always_comb begin
        w_alu_a   = r_a;
        w_alu_b   = r_b;
        w_alu_ctl = ALU_ADD;
        case (r_state)
            FETCH: begin
                w_alu_a = r_pc;
                w_alu_b = 32'd4;
            end
            DECODE: begin
                w_alu_a = r_pc;
                w_alu_b = {w_simm[29:0], 2'b00};
            end
            EXECUTE: w_alu_ctl = funct_alu(w_funct);
            IEXEC: begin
                w_alu_b = (w_op == ADDI) ? w_simm : w_zimm;
                if (w_op == ANDI) w_alu_ctl = ALU_AND;
                else if (w_op == ORI) w_alu_ctl = ALU_OR;
            end
            MEMADR: w_alu_b = w_simm;
            BRANCH: w_alu_ctl = ALU_SUB;
            default: ;
        endcase
    end

    mips_alu u_alu (
        .a          (w_alu_a),
        .b          (w_alu_b),
        .alucontrol (w_alu_ctl),
        .y          (w_alu_y),
        .zero       (w_alu_zero)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET: w_next = FETCH;
            FETCH: if (mem_ready) w_next = DECODE;
            DECODE: begin
                case (w_op)
                    RTYPE:           w_next = funct_ok(w_funct) ? EXECUTE : TRAP;
                    LW, SW:          w_next = MEMADR;
                    BEQ, BNE:        w_next = BRANCH;
                    ADDI, ANDI, ORI: w_next = IEXEC;
                    J:               w_next = JUMP;
                    default:         w_next = TRAP;
                endcase
            end
            EXECUTE: w_next = ALUWB;
            IEXEC:   w_next = IWB;
            // Alignment is judged on the address being computed this cycle.
            MEMADR: begin
                if (w_alu_y[1:0] != 2'b00) w_next = TRAP;
                else if (w_op == LW) w_next = MEMRD;
                else w_next = MEMWR;
            end
            MEMRD: if (mem_ready) w_next = MEMWB;
            MEMWR: if (mem_ready) w_next = FETCH;
            ALUWB, IWB, MEMWB, BRANCH, JUMP: w_next = FETCH;
            TRAP:    w_next = TRAP;
            default: w_next = TRAP;
        endcase
    end

    assign w_take = ((w_op == BEQ) && w_alu_zero) ||
                    ((w_op == BNE) && !w_alu_zero);

    assign w_done = (r_state inside {ALUWB, IWB, MEMWB, BRANCH, JUMP}) ||
                    ((r_state == MEMWR) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RESET;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            r_retire  <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state  <= w_next;
            r_retire <= w_done;
            if (w_done) r_instret <= r_instret + CNT_W'(1);
            case (r_state)
                FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= w_alu_y;
                    end
                end
                DECODE: begin
                    r_a      <= r_rf[w_rs];
                    r_b      <= r_rf[w_rt];
                    r_aluout <= w_alu_y;
                end
                EXECUTE, IEXEC, MEMADR: r_aluout <= w_alu_y;
                MEMRD: if (mem_ready) r_mdr <= mem_rdata;
                BRANCH: if (w_take) r_pc <= r_aluout;
                JUMP: r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

    assign w_rf_wa = (r_state == ALUWB) ? w_rd : w_rt;
    assign w_rf_wd = (r_state == MEMWB) ? r_mdr : r_aluout;
    assign w_rf_we = (r_state inside {ALUWB, IWB, MEMWB}) &&
                     (w_rf_wa != 5'd0);

    // $0 is never written, so it reads zero without a read-side mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_rf_we) begin
            r_rf[w_rf_wa] <= w_rf_wd;
        end
    end

    assign w_addr    = (r_state == FETCH) ? r_pc : r_aluout;
    assign mem_req   = r_state inside {FETCH, MEMRD, MEMWR};
    assign mem_we    = (r_state == MEMWR);
    assign mem_addr  = w_addr[ADDR_W-1:0];
    assign mem_wdata = r_b;
    assign pc        = r_pc;
    assign retire    = r_retire;
    assign instret   = r_instret;
    assign halted    = (r_state == TRAP);

endmodule

// File: tb/tb_multicycle_mips.sv
// Scoreboard bench for multicycle_mips: wait-state memory model,
// expected retires and stores queued up front, popped as they occur.
module tb_multicycle_mips;

    localparam logic [5:0] O_LW   = 6'h23;
    localparam logic [5:0] O_SW   = 6'h2b;
    localparam logic [5:0] O_BEQ  = 6'h04;
    localparam logic [5:0] O_BNE  = 6'h05;
    localparam logic [5:0] O_ADDI = 6'h08;
    localparam logic [5:0] O_ANDI = 6'h0c;
    localparam logic [5:0] O_ORI  = 6'h0d;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2a;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
        int          n;
    } ret_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] instret;
    logic        halted;

    always #5 clk = ~clk;

    multicycle_mips #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32),
        .CNT_W    (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .pc        (pc),
        .retire    (retire),
        .instret   (instret),
        .halted    (halted)
    );

    logic [31:0] mem [256];
    int          W = 0;
    int          wcnt = 0;
    int          cyc = 0;
    int          n_hs = 0;
    logic        ld_en = 1'b0;
    logic        ld_clr = 1'b0;
    logic [7:0]  ld_a = '0;
    logic [31:0] ld_d = '0;

    assign mem_rdata = mem[mem_addr[9:2]];
    assign mem_ready = mem_req && (wcnt == W);

    always @(posedge clk) begin
        if (ld_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ld_en) begin
            mem[ld_a] <= ld_d;
        end else if (mem_req && mem_we && mem_ready) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
        wcnt <= (mem_req && !mem_ready) ? wcnt + 1 : 0;
        cyc  <= rst_n ? cyc + 1 : 0;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    ret_t q_ret[$];
    wr_t  q_wr[$];
    logic [31:0] prog[$];
    int   t = 1;
    int   n = 0;
    int   hs0 = 0;

    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            n_hs <= n_hs + 1;
            if (mem_we) begin
                if (q_wr.size() == 0) begin
                    chk("wr_extra", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    chk("wr_addr", mem_addr, q_wr[0].a);
                    chk("wr_data", mem_wdata, q_wr[0].d);
                    q_wr.delete(0);
                end
            end
        end
        if (retire) begin
            if (q_ret.size() == 0) begin
                chk("ret_extra", pc, 32'hFFFF_FFFF);
            end else begin
                chk("ret_pc", pc, q_ret[0].pc);
                chk("ret_cyc", 32'(cyc), 32'(q_ret[0].cyc));
                chk("ret_instret", instret, 32'(q_ret[0].n));
                q_ret.delete(0);
            end
        end
    end

    function automatic logic [31:0] ri(input logic [5:0] op,
        input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rr(input logic [5:0] fn,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] jw(input logic [25:0] tgt);
        return {6'h02, tgt};
    endfunction

    task automatic begin_prog(input int waits);
        W = waits;
        t = 1;
        n = 0;
        hs0 = n_hs;
        q_ret.delete();
        q_wr.delete();
        prog.delete();
    endtask

    task automatic add(input logic [31:0] w);
        prog.push_back(w);
    endtask

    // Expected retire: next pc, base latency, memory accesses.
    task automatic er(input logic [31:0] npc, input int lat, input int m);
        t = t + lat + m * W;
        n++;
        q_ret.push_back('{pc: npc, cyc: t, n: n});
    endtask

    task automatic ew(input logic [31:0] a, input logic [31:0] d);
        q_wr.push_back('{a: a, d: d});
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_a = a[9:2];
        ld_d = d;
        ld_en = 1'b1;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic load_prog();
        ld_clr = 1'b1;
        @(posedge clk);
        #1;
        ld_clr = 1'b0;
        for (int i = 0; i < prog.size(); i++) load(32'(4 * i), prog[i]);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("fetch_req", 32'(mem_req), 32'd1);
        chk("fetch_we", 32'(mem_we), 32'd0);
        chk("fetch_addr", mem_addr, 32'h0000_0000);
    endtask

    task automatic wait_halt(input logic [31:0] hpc, input int extra,
                             input int hs);
        int k;
        k = 0;
        while (!halted && k < 800) begin
            @(negedge clk);
            k++;
        end
        chk("halted", 32'(halted), 32'd1);
        chk("halt_cyc", 32'(cyc), 32'(t + extra + W));
        chk("halt_pc", pc, hpc);
        chk("halt_instret", instret, 32'(n));
        repeat (4) begin
            @(negedge clk);
            chk("trap_req", 32'(mem_req), 32'd0);
        end
        chk("trap_pc", pc, hpc);
        chk("trap_instret", instret, 32'(n));
        chk("ret_left", 32'(q_ret.size()), 32'd0);
        chk("wr_left", 32'(q_wr.size()), 32'd0);
        chk("hs_count", 32'(n_hs - hs0), 32'(hs));
        rst_n = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0000_0000);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_instret", instret, 32'd0);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        begin_prog(0);
        load_prog();
        @(negedge clk);
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_pc", pc, 32'h0000_0000);
        chk("reset_instret", instret, 32'd0);
        chk("reset_retire", 32'(retire), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);

        // ALU ops, stores, $0 write, jump, illegal opcode; zero wait.
        begin_prog(0);
        add(ri(O_ADDI, 5'd0, 5'd1, 16'd5));    er(32'd4, 4, 1);
        add(ri(O_ADDI, 5'd0, 5'd2, 16'hFFFD)); er(32'd8, 4, 1);
        add(rr(F_ADD, 5'd1, 5'd2, 5'd3));      er(32'd12, 4, 1);
        add(rr(F_SLT, 5'd2, 5'd1, 5'd5));      er(32'd16, 4, 1);
        add(ri(O_ANDI, 5'd2, 5'd6, 16'hFFFF)); er(32'd20, 4, 1);
        add(ri(O_ORI, 5'd0, 5'd7, 16'h8001));  er(32'd24, 4, 1);
        add(rr(F_SUB, 5'd1, 5'd2, 5'd8));      er(32'd28, 4, 1);
        add(rr(F_OR, 5'd1, 5'd2, 5'd9));       er(32'd32, 4, 1);
        add(rr(F_AND, 5'd1, 5'd6, 5'd10));     er(32'd36, 4, 1);
        add(ri(O_SW, 5'd0, 5'd3, 16'h0200));   er(32'd40, 4, 2);
        ew(32'h200, 32'h0000_0002);
        add(ri(O_SW, 5'd0, 5'd5, 16'h0204));   er(32'd44, 4, 2);
        ew(32'h204, 32'h0000_0001);
        add(ri(O_SW, 5'd0, 5'd6, 16'h0208));   er(32'd48, 4, 2);
        ew(32'h208, 32'h0000_FFFD);
        add(ri(O_SW, 5'd0, 5'd7, 16'h020C));   er(32'd52, 4, 2);
        ew(32'h20C, 32'h0000_8001);
        add(ri(O_SW, 5'd0, 5'd8, 16'h0210));   er(32'd56, 4, 2);
        ew(32'h210, 32'h0000_0008);
        add(ri(O_SW, 5'd0, 5'd9, 16'h0214));   er(32'd60, 4, 2);
        ew(32'h214, 32'hFFFF_FFFD);
        add(ri(O_SW, 5'd0, 5'd10, 16'h0218));  er(32'd64, 4, 2);
        ew(32'h218, 32'h0000_0005);
        add(ri(O_ADDI, 5'd0, 5'd0, 16'd9));    er(32'd68, 4, 1);
        add(ri(O_SW, 5'd0, 5'd0, 16'h021C));   er(32'd72, 4, 2);
        ew(32'h21C, 32'h0000_0000);
        add(jw(26'h40));                       er(32'h100, 3, 1);
        load_prog();
        load(32'h100, 32'hFC00_0000);
        release_rst();
        wait_halt(32'h104, 2, 28);

        // Store/load and branches with two wait states per access.
        begin_prog(2);
        add(ri(O_ADDI, 5'd0, 5'd1, 16'd5));    er(32'd4, 4, 1);
        add(ri(O_ADDI, 5'd0, 5'd2, 16'd5));    er(32'd8, 4, 1);
        add(ri(O_ADDI, 5'd0, 5'd3, 16'd2));    er(32'd12, 4, 1);
        add(ri(O_SW, 5'd0, 5'd3, 16'h0200));   er(32'd16, 4, 2);
        ew(32'h200, 32'h0000_0002);
        add(ri(O_LW, 5'd0, 5'd4, 16'h0200));   er(32'd20, 5, 2);
        add(ri(O_SW, 5'd0, 5'd4, 16'h0204));   er(32'd24, 4, 2);
        ew(32'h204, 32'h0000_0002);
        add(ri(O_BEQ, 5'd1, 5'd2, 16'd2));     er(32'd36, 3, 1);
        add(ri(O_ADDI, 5'd0, 5'd9, 16'd1));
        add(ri(O_SW, 5'd0, 5'd9, 16'h0208));
        add(ri(O_BNE, 5'd1, 5'd2, 16'd2));     er(32'd40, 3, 1);
        add(ri(O_ADDI, 5'd0, 5'd10, 16'd7));   er(32'd44, 4, 1);
        add(ri(O_BNE, 5'd1, 5'd3, 16'd2));     er(32'd56, 3, 1);
        add(ri(O_SW, 5'd0, 5'd9, 16'h0208));
        add(ri(O_ADDI, 5'd0, 5'd10, 16'd99));
        add(ri(O_SW, 5'd0, 5'd10, 16'h020C));  er(32'd60, 4, 2);
        ew(32'h20C, 32'h0000_0007);
        add(ri(O_BEQ, 5'd1, 5'd3, 16'd5));     er(32'd64, 3, 1);
        add(ri(O_LW, 5'd0, 5'd1, 16'd2));
        load_prog();
        release_rst();
        wait_halt(32'd68, 3, 17);

        // Reset while a load waits on memory, then a clean rerun.
        begin_prog(4);
        add(ri(O_LW, 5'd0, 5'd1, 16'h0200));
        add(32'h0000_0000);
        load_prog();
        release_rst();
        k = 0;
        while (!(mem_req && !mem_we && mem_addr == 32'h200) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("memrd_seen", 32'(k < 100), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_addr", mem_addr, 32'h0000_0000);
        chk("abort_pc", pc, 32'h0000_0000);
        chk("abort_retire", 32'(retire), 32'd0);
        chk("abort_halted", 32'(halted), 32'd0);
        chk("abort_instret", instret, 32'd0);
        begin_prog(4);
        er(32'd4, 5, 2);
        release_rst();
        wait_halt(32'd8, 2, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
